program_loader: RTL and testbench
=================================

# program_loader

Serial boot loader that writes the instruction memory, the writer side of the processor's instruction-fetch read path. Receives a framed program image over an 8N1 UART line, assembles big-endian 32-bit words, and issues one write per word to the instruction memory's write port. It holds the processor in reset while loading and releases it only after a checksum-verified image. It sits beside the instruction memory, on the same clock as the board-level logic.

## Interface
Parameters:
- CLKS_PER_BIT, 5208, clock cycles per UART bit (50 MHz / 9600 baud); must be ≥ 4.
- ADDR_W, 8, instruction-memory word-address width (256 words).
- TIMEOUT_CYCLES, 2_000_000, maximum idle cycles between bytes inside a frame.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- rx  in  1  UART serial input, idle high, asynchronous to clock.
- mem_we  out  1  one-cycle write strobe to instruction memory.
- mem_addr  out  ADDR_W  word address for the current write.
- mem_wdata  out  32  word to write.
- cpu_hold  out  1  high = processor held in reset.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse on successful load.
- error  out  1  sticky fault flag.

## Operation
- Frame: 0xA5 sync, count byte N (0 encodes 256 words), N×4 data bytes MSB first, checksum byte = 8-bit sum mod 256 of all data bytes.
- Byte receiver: 2-flop synchronizer on rx. A falling edge starts a byte; the start bit is rechecked at mid-bit (high = glitch, return to idle). 8 data bits are sampled LSB first at bit centres, then the stop bit. Stop bit 0 produces a framing-error pulse and no byte.
- FSM states:
  - IDLE: wait for a byte. Bytes other than 0xA5 and framing errors are ignored. On 0xA5: error←0, cpu_hold←1, busy←1, checksum←0, mem_addr←0, go to COUNT.
  - COUNT: latch N (0→256), go to DATA.
  - DATA: shift each byte into the word register and add it to the checksum. On the 4th byte: mem_wdata←word and mem_we←1 for one cycle. mem_addr increments after each write, wrapping mod 2^ADDR_W. Go to CSUM after word N.
  - CSUM: on a match, pulse done, drop cpu_hold and busy, go to IDLE. On a mismatch, set error, drop busy, keep cpu_hold high, go to IDLE.
- Framing error or timeout in COUNT, DATA or CSUM: error←1, busy←0, cpu_hold stays 1, go to IDLE. Already-written words are not rolled back.
- 0xA5 received in DATA or CSUM is treated as data or checksum, never as a resync.
- Only a later successful frame or reset clears cpu_hold after an error.

## Timing
- Reset values: every output 0, FSM IDLE, receiver idle.
- Byte valid is asserted 1 cycle after the stop-bit sample. mem_we follows 1 cycle after the 4th byte's valid. done follows 1 cycle after the checksum byte's valid.
- mem_addr and mem_wdata are stable during the mem_we cycle and hold afterwards.
- Timeout counter resets on every valid byte and runs only outside IDLE. It fires when the count reaches TIMEOUT_CYCLES.
- Reset mid-frame aborts immediately. No write is issued after reset asserts.

## Structure
- Shared package: SYNC_BYTE = 8'hA5 and the FSM state enum (IDLE, COUNT, DATA, CSUM).
- One sub-module: uart_rx (synchronizer, bit timing, byte output, valid and framing-error pulses), parameterized by CLKS_PER_BIT.
- program_loader holds the FSM, word assembly, address counter, checksum and timeout.

## Test plan
- Nominal frame A5 02 20 01 00 05 00 00 00 00 26, checked with CLKS_PER_BIT=8:
  - mem_we twice: addr 0 / 0x20010005, then addr 1 / 0x00000000.
  - done pulses once; cpu_hold 1→0; error stays 0.
- Same frame with checksum 0x27: both writes occur, no done, error=1, cpu_hold stays 1. A following correct frame clears error and drops cpu_hold.
- Bytes 00 FF 5A before the nominal frame: ignored, with no cpu_hold or busy change. The load then succeeds exactly as the nominal case.
- Stop bit forced 0 on the 3rd data byte: error=1, busy=0, FSM in IDLE, no further mem_we.
- Reset asserted mid-DATA: all outputs 0 in the same cycle; the next nominal frame loads correctly from addr 0.
- TIMEOUT_CYCLES=100, line idle after the count byte: error=1 after 100 cycles. A 1-cycle rx low glitch is rejected with no byte and no error.

Source files
------------

// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared constants and FSM state type for the serial boot loader
package program_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DATA  = 2'd2,
        CSUM  = 2'd3
    } state_t;

endpackage

// File: rtl/program_loader_uart_rx.sv
// uart_rx: 8N1 byte receiver with input synchronizer, mid-bit start recheck and framing-error pulse
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       ferr
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [1:0] R_IDLE = 2'd0, R_START = 2'd1, R_DATA = 2'd2, R_STOP = 2'd3;

    logic [1:0]    sync;
    logic          prev;
    logic [1:0]    st;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic          tick;

    assign tick = (st == R_START) ? (cnt == HALF) : (cnt == FULL);

    // synchronize rx, find the start edge, then sample each bit at its centre
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync    <= 2'b11;
            prev    <= 1'b1;
            st      <= R_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            data    <= '0;
            valid   <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            sync  <= {sync[0], rx};
            prev  <= sync[1];
            valid <= 1'b0;
            ferr  <= 1'b0;
            cnt   <= (st == R_IDLE || tick) ? '0 : cnt + 1'b1;
            case (st)
                R_IDLE:  if (prev && !sync[1]) st <= R_START;
                R_START: if (tick) st <= sync[1] ? R_IDLE : R_DATA;
                R_DATA: if (tick) begin
                    data    <= {sync[1], data[7:1]};
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == 3'd7) st <= R_STOP;
                end
                R_STOP: if (tick) begin
                    valid <= sync[1];
                    ferr  <= ~sync[1];
                    st    <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/program_loader.sv
// program_loader: receives a framed, checksummed program image over UART and writes it into instruction memory
module program_loader
    import program_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 5208,
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ferr;
    state_t        state;
    logic [23:0]   word;
    logic [1:0]    byte_idx;
    logic [8:0]    left;
    logic [7:0]    csum;
    logic [TW-1:0] tcnt;
    logic          timeout;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clock(clock),
        .reset(reset),
        .rx(rx),
        .data(rx_data),
        .valid(rx_valid),
        .ferr(rx_ferr)
    );

    assign timeout = (state != IDLE) && (tcnt == TW'(TIMEOUT_CYCLES));

    // inter-byte idle timer, only armed while a frame is open
    always_ff @(posedge clock or posedge reset) begin
        if (reset) tcnt <= '0;
        else       tcnt <= (state == IDLE || rx_valid) ? '0 : tcnt + 1'b1;
    end

    // frame FSM: sync, word count, data words with running checksum, checksum verify
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            word      <= '0;
            byte_idx  <= '0;
            left      <= '0;
            csum      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            if (mem_we) mem_addr <= mem_addr + 1'b1;
            if (state != IDLE && (rx_ferr || timeout)) begin
                error <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
            end else if (rx_valid) begin
                case (state)
                    IDLE: if (rx_data == SYNC_BYTE) begin
                        error    <= 1'b0;
                        cpu_hold <= 1'b1;
                        busy     <= 1'b1;
                        csum     <= '0;
                        mem_addr <= '0;
                        byte_idx <= '0;
                        state    <= COUNT;
                    end
                    COUNT: begin
                        left  <= {rx_data == 8'd0, rx_data};
                        state <= DATA;
                    end
                    DATA: begin
                        word     <= {word[15:0], rx_data};
                        csum     <= csum + rx_data;
                        byte_idx <= byte_idx + 1'b1;
                        if (byte_idx == 2'd3) begin
                            mem_wdata <= {word, rx_data};
                            mem_we    <= 1'b1;
                            left      <= left - 1'b1;
                            if (left == 9'd1) state <= CSUM;
                        end
                    end
                    CSUM: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                        if (rx_data == csum) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized frame stimulus with a write scoreboard for program_loader
module tb_program_loader;

    localparam int CPB = 8;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    int  total = 0;
    int  bad = 0;
    int  done_cnt = 0;
    wr_t exp_q[$];
    wr_t e;

    program_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(8), .TIMEOUT_CYCLES(100)) dut (
        .clock(clock),
        .reset(reset),
        .rx(rx),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // monitor: every write strobe must match the oldest expected write
    always @(negedge clock) begin
        if (!reset && mem_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h want no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e.a));
                check("wr_data", 64'(mem_wdata), 64'(e.d));
            end
        end
        if (!reset && done) done_cnt++;
    end

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        rx = 1'b0;
        repeat (CPB) @(posedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clock);
        end
        rx = ~bad_stop;
        repeat (CPB) @(posedge clock);
        rx = 1'b1;
    endtask

    function automatic bq_t make_frame(input int n, input bit corrupt);
        bq_t f;
        logic [7:0] s = 8'd0;
        logic [7:0] b;
        f.push_back(8'hA5);
        f.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            f.push_back(b);
            s = s + b;
        end
        f.push_back(corrupt ? s + 8'd1 : s);
        return f;
    endfunction

    // model: whole words present are written from address 0; success iff sum of data bytes matches
    task automatic run_frame(input bq_t f, input int glitch_at);
        int n = (f[1] == 8'd0) ? 256 : int'(f[1]);
        logic [7:0] s = 8'd0;
        bit ok;
        int d0 = done_cnt;
        for (int i = 0; i < 4 * n; i++) s = s + f[2 + i];
        ok = (f.size() == 3 + 4 * n) && (s == f[f.size() - 1]);
        for (int w = 0; w < n; w++)
            exp_q.push_back('{a: 8'(w), d: {f[2 + 4 * w], f[3 + 4 * w], f[4 + 4 * w], f[5 + 4 * w]}});
        foreach (f[i]) begin
            if (i == glitch_at) begin
                rx = 1'b0;
                @(posedge clock);
                rx = 1'b1;
                repeat (12) @(posedge clock);
            end
            send_byte(f[i], 1'b0);
            if (i == 0) begin
                repeat (2) @(posedge clock);
                @(negedge clock);
                check("hold_in_frame", 64'({cpu_hold, busy, error}), 64'(3'b110));
            end else if (glitch_at < 0) begin
                repeat ($urandom_range(0, 5)) @(posedge clock);
            end
        end
        repeat (4) @(posedge clock);
        @(negedge clock);
        check("done_count", 64'(done_cnt - d0), 64'(ok));
        check("error_after", 64'(error), 64'(!ok));
        check("hold_after", 64'(cpu_hold), 64'(!ok));
        check("busy_after", 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bq_t nom, badf, pre, head;
        nom  = '{8'hA5, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h26};
        badf = '{8'hA5, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h27};
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_outputs", 64'({mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error}), 64'd0);
        reset = 1'b0;
        repeat (20) @(posedge clock);

        run_frame(nom, -1);
        run_frame(badf, -1);
        run_frame(nom, -1);

        pre = '{8'h00, 8'hFF, 8'h5A};
        foreach (pre[i]) begin
            send_byte(pre[i], 1'b0);
            repeat (3) @(posedge clock);
            @(negedge clock);
            check("garbage_ignored", 64'({cpu_hold, busy, error}), 64'd0);
        end
        run_frame(nom, -1);

        head = '{8'hA5, 8'h02, 8'h20, 8'h01};
        foreach (head[i]) send_byte(head[i], 1'b0);
        send_byte(8'h00, 1'b1);
        repeat (4) @(posedge clock);
        @(negedge clock);
        check("ferr_state", 64'({cpu_hold, busy, error}), 64'(3'b101));
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        repeat (4) @(posedge clock);
        @(negedge clock);
        check("ferr_idle", 64'({cpu_hold, busy, error}), 64'(3'b101));
        run_frame(nom, -1);

        exp_q.push_back('{a: 8'h00, d: 32'h20010005});
        head = '{8'hA5, 8'h03, 8'h20, 8'h01, 8'h00, 8'h05, 8'h77, 8'h88};
        foreach (head[i]) send_byte(head[i], 1'b0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("busy_before_reset", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("reset_mid_frame", 64'({mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error}), 64'd0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("queue_after_reset", 64'(exp_q.size()), 64'd0);
        repeat (10) @(posedge clock);
        run_frame(nom, -1);

        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        repeat (80) @(posedge clock);
        @(negedge clock);
        check("timeout_not_yet", 64'({cpu_hold, busy, error}), 64'(3'b110));
        repeat (35) @(posedge clock);
        @(negedge clock);
        check("timeout_fired", 64'({cpu_hold, busy, error}), 64'(3'b101));

        run_frame(nom, 5);
        rx = 1'b0;
        @(posedge clock);
        rx = 1'b1;
        repeat (30) @(posedge clock);
        @(negedge clock);
        check("idle_glitch", 64'({cpu_hold, busy, error}), 64'd0);

        for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(0, 2)) begin
                logic [7:0] g = 8'($urandom);
                send_byte(g == 8'hA5 ? 8'h5A : g, 1'b0);
            end
            run_frame(make_frame($urandom_range(1, 4), $urandom_range(0, 3) == 0), -1);
        end

        repeat (10) @(posedge clock);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
